// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I control slice.
//   - opcode constants for the supported instruction classes
//   - ALU operation codes (producer side of the ALU interface)
//   - mux select encodings for result_src, alu_src_a, alu_src_b, imm_src
//   - FSM state enum and the ALU-decode class enum
//   - imm_src_for(): immediate format selected purely from the opcode
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;  // registered ALU result
  localparam logic [1:0] RES_DATA   = 2'b01;  // read data register
  localparam logic [1:0] RES_ALU    = 2'b10;  // live alu_result

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTER  = 4'd6,
    S_EXECUTEI  = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_AUIPC     = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_t;

  // What the ALU is being used for in the current state.
  typedef enum logic [1:0] {
    ALU_CLS_ADD,     // address / PC arithmetic
    ALU_CLS_BRANCH,  // compare for branch resolution
    ALU_CLS_EXEC_R,  // register-register op
    ALU_CLS_EXEC_I   // register-immediate op or LUI
  } alu_cls_t;

  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
//   funct3, funct7b5 : instruction fields from the instruction register
//   op5              : op[5]; in the immediate class it separates LUI from OP-IMM
//   cls              : what the current FSM state uses the ALU for
//   alu_control      : 4-bit ALU op code
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  input  alu_cls_t   cls,
  output logic [3:0] alu_control
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    alu_control = ALU_ADD;
    case (cls)
      ALU_CLS_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_control = ALU_SUB;   // beq / bne
          3'b100, 3'b101: alu_control = ALU_SLT;   // blt / bge
          3'b110, 3'b111: alu_control = ALU_SLTU;  // bltu / bgeu
          default:        alu_control = ALU_ADD;
        endcase
      end
      ALU_CLS_EXEC_R, ALU_CLS_EXEC_I: begin
        if (cls == ALU_CLS_EXEC_I && op5) begin
          alu_control = ALU_LUI;
        end else begin
          case (funct3)
            // funct7b5 on an immediate add is just immediate bit 10, not sub.
            3'b000: alu_control = (cls == ALU_CLS_EXEC_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_control = ALU_SLL;
            3'b010: alu_control = ALU_SLT;
            3'b011: alu_control = ALU_SLTU;
            3'b100: alu_control = ALU_XOR;
            // srai carries funct7b5 as well, so both classes honour it here.
            3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_control = ALU_OR;
            default: alu_control = ALU_AND;
          endcase
        end
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit (Moore FSM) driving the datapath.
//   clk, reset (async, active high)
//   op, funct3, funct7b5  : latched instruction fields
//   zero                  : ALU zero flag, used for branch resolution
//   mem_ready             : memory access completes this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write : datapath enables / address mux
//   result_src, alu_src_a, alu_src_b, imm_src         : datapath mux selects
//   alu_control           : ALU op code
//   illegal_instr         : one-cycle pulse for unsupported op/funct3
//   state_dbg             : current FSM state
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         imm_src,
  output logic [3:0]         alu_control,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

  state_t   state;
  alu_cls_t alu_cls;
  logic     mem_ok;
  logic     branch_f3_bad;
  logic     branch_taken;

  assign mem_ok        = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign branch_f3_bad = (funct3[2:1] == 2'b01);
  // beq, bge, bgeu take the branch on zero; bne, blt, bltu on non-zero.
  assign branch_taken  = (funct3 == 3'b000 || funct3 == 3'b101 || funct3 == 3'b111) ? zero : !zero;

  assign imm_src   = imm_src_for(op);
  assign state_dbg = STATE_W'(state);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ok) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE:  state <= S_MEMADR;
            OP_RTYPE:           state <= S_EXECUTER;
            OP_ITYPE, OP_LUI:   state <= S_EXECUTEI;
            OP_BRANCH:          state <= branch_f3_bad ? S_ILLEGAL : S_BRANCH;
            OP_JAL:             state <= S_JAL;
            OP_JALR:            state <= S_JALR;
            OP_AUIPC:           state <= S_AUIPC;
            default:            state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ok) state <= S_MEMWB;
        S_MEMWRITE: if (mem_ok) state <= S_FETCH;
        S_EXECUTER, S_EXECUTEI, S_AUIPC, S_JAL: state <= S_ALUWB;
        S_JALR:     state <= S_JALR_LINK;
        default:    state <= S_FETCH;  // MEMWB, ALUWB, BRANCH, JALR_LINK, ILLEGAL
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_cls       = ALU_CLS_ADD;

    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_write   = mem_ok;
        ir_write   = mem_ok;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_cls   = ALU_CLS_EXEC_R;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_cls   = ALU_CLS_EXEC_I;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_cls   = ALU_CLS_BRANCH;
        pc_write  = branch_taken;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;  // ALUOut still holds the target computed in DECODE
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
      end
      S_JALR_LINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
      end
      S_ILLEGAL:  illegal_instr = 1'b1;
      default: ;
    endcase

    // State is already FETCH while reset is high, but FETCH would otherwise
    // pass mem_ready straight through to pc_write/ir_write.
    if (reset) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .cls         (alu_cls),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded
// into its expected per-cycle step list (from the instruction class), and the
// DUT is walked through it with random mem_ready / zero inputs.
module tb_multicycle_control;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
  localparam logic [6:0] T_I = 7'b0010011, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_BR = 7'b1100011, T_JAL = 7'b1101111, T_JALR = 7'b1100111;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_OR = 4'd2, A_AND = 4'd3, A_XOR = 4'd4;
  localparam logic [3:0] A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_SRA = 4'd8, A_SLTU = 4'd9;
  localparam logic [3:0] A_LUI = 4'd15;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control, state_dbg;

  multicycle_control #(.MEM_WAIT_EN(1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    bit         wait_mem, fetch_gate, br, br_on_zero, pcw, adr, memw, regw, ill;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu;
  } step_t;

  step_t plan[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    wait_cycles;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic step_t mk(input logic [3:0] st, input logic [1:0] sa, input logic [1:0] sb,
                               input logic [1:0] rs, input logic [3:0] alu);
    step_t s;
    s.st = st; s.sa = sa; s.sb = sb; s.rs = rs; s.alu = alu;
    s.wait_mem = 0; s.fetch_gate = 0; s.br = 0; s.br_on_zero = 0;
    s.pcw = 0; s.adr = 0; s.memw = 0; s.regw = 0; s.ill = 0;
    return s;
  endfunction

  function automatic logic [3:0] arith_alu(input logic [2:0] f3, input bit f7, input bit is_r);
    case (f3)
      3'd0: return (is_r && f7) ? A_SUB : A_ADD;
      3'd1: return A_SLL;
      3'd2: return A_SLT;
      3'd3: return A_SLTU;
      3'd4: return A_XOR;
      3'd5: return f7 ? A_SRA : A_SRL;
      3'd6: return A_OR;
      default: return A_AND;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    if (o == T_STORE) return 3'b001;
    if (o == T_BR) return 3'b010;
    if (o == T_JAL) return 3'b011;
    if (o == T_LUI || o == T_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  // Expected sequence of control steps for one instruction.
  task automatic build_plan(input logic [6:0] o, input logic [2:0] f3, input bit f7);
    step_t s, wb, ill;
    plan.delete();
    wb = mk(riscv_pkg::S_ALUWB, 2'b00, 2'b00, 2'b00, A_ADD);
    wb.regw = 1;
    ill = mk(riscv_pkg::S_ILLEGAL, 2'b00, 2'b00, 2'b00, A_ADD);
    ill.ill = 1;
    s = mk(riscv_pkg::S_FETCH, 2'b00, 2'b10, 2'b10, A_ADD);
    s.wait_mem = 1; s.fetch_gate = 1;
    plan.push_back(s);
    plan.push_back(mk(riscv_pkg::S_DECODE, 2'b01, 2'b01, 2'b00, A_ADD));
    case (o)
      T_LOAD, T_STORE: begin
        plan.push_back(mk(riscv_pkg::S_MEMADR, 2'b10, 2'b01, 2'b00, A_ADD));
        if (o == T_LOAD) begin
          s = mk(riscv_pkg::S_MEMREAD, 2'b00, 2'b00, 2'b00, A_ADD);
          s.adr = 1; s.wait_mem = 1;
          plan.push_back(s);
          s = mk(riscv_pkg::S_MEMWB, 2'b00, 2'b00, 2'b01, A_ADD);
          s.regw = 1;
          plan.push_back(s);
        end else begin
          s = mk(riscv_pkg::S_MEMWRITE, 2'b00, 2'b00, 2'b00, A_ADD);
          s.adr = 1; s.memw = 1; s.wait_mem = 1;
          plan.push_back(s);
        end
      end
      T_R: begin
        plan.push_back(mk(riscv_pkg::S_EXECUTER, 2'b10, 2'b00, 2'b00, arith_alu(f3, f7, 1)));
        plan.push_back(wb);
      end
      T_I: begin
        plan.push_back(mk(riscv_pkg::S_EXECUTEI, 2'b10, 2'b01, 2'b00, arith_alu(f3, f7, 0)));
        plan.push_back(wb);
      end
      T_LUI: begin
        plan.push_back(mk(riscv_pkg::S_EXECUTEI, 2'b10, 2'b01, 2'b00, A_LUI));
        plan.push_back(wb);
      end
      T_AUIPC: begin
        plan.push_back(mk(riscv_pkg::S_AUIPC, 2'b01, 2'b01, 2'b00, A_ADD));
        plan.push_back(wb);
      end
      T_BR: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          plan.push_back(ill);
        end else begin
          s = mk(riscv_pkg::S_BRANCH, 2'b10, 2'b00, 2'b00,
                 (f3 < 3'd4) ? A_SUB : (f3 < 3'd6) ? A_SLT : A_SLTU);
          s.br = 1;
          s.br_on_zero = (f3 == 3'b000 || f3 == 3'b101 || f3 == 3'b111);
          plan.push_back(s);
        end
      end
      T_JAL: begin
        s = mk(riscv_pkg::S_JAL, 2'b01, 2'b10, 2'b00, A_ADD);
        s.pcw = 1;
        plan.push_back(s);
        plan.push_back(wb);
      end
      T_JALR: begin
        s = mk(riscv_pkg::S_JALR, 2'b10, 2'b01, 2'b10, A_ADD);
        s.pcw = 1;
        plan.push_back(s);
        s = mk(riscv_pkg::S_JALR_LINK, 2'b01, 2'b10, 2'b10, A_ADD);
        s.regw = 1;
        plan.push_back(s);
      end
      default: plan.push_back(ill);
    endcase
  endtask

  task automatic check_cycle(input step_t s, input bit mr, input bit z);
    string sfx;
    bit    exp_pcw;
    sfx = $sformatf("@st%0d op%0h f3%0d", s.st, op, funct3);
    exp_pcw = s.fetch_gate ? mr : s.br ? (s.br_on_zero ? z : !z) : s.pcw;
    check({"state_dbg", sfx}, 32'(state_dbg), 32'(s.st));
    check({"pc_write", sfx}, 32'(pc_write), 32'(exp_pcw));
    check({"ir_write", sfx}, 32'(ir_write), 32'(s.fetch_gate && mr));
    check({"adr_src", sfx}, 32'(adr_src), 32'(s.adr));
    check({"mem_write", sfx}, 32'(mem_write), 32'(s.memw));
    check({"reg_write", sfx}, 32'(reg_write), 32'(s.regw));
    check({"illegal_instr", sfx}, 32'(illegal_instr), 32'(s.ill));
    check({"result_src", sfx}, 32'(result_src), 32'(s.rs));
    check({"alu_src_a", sfx}, 32'(alu_src_a), 32'(s.sa));
    check({"alu_src_b", sfx}, 32'(alu_src_b), 32'(s.sb));
    check({"alu_control", sfx}, 32'(alu_control), 32'(s.alu));
    check({"imm_src", sfx}, 32'(imm_src), 32'(exp_imm(op)));
  endtask

  // Called at posedge+1 with the DUT in FETCH. mem_wait < 0: random mem_ready;
  // otherwise FETCH sees mem_ready=1 and memory states see mem_wait low cycles.
  // zero_fix < 0: random zero, else held at that value.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                           input int mem_wait, input int zero_fix);
    bit mr, z, adv;
    int cyc;
    step_t s;
    build_plan(o, f3, f7);
    op = o; funct3 = f3; funct7b5 = f7;
    foreach (plan[i]) begin
      s = plan[i];
      cyc = 0;
      adv = 0;
      do begin
        if (mem_wait < 0) mr = ($urandom_range(0, 3) != 0);
        else if (s.fetch_gate) mr = 1;
        else if (s.wait_mem) mr = (cyc >= mem_wait);
        else mr = 1'($urandom_range(0, 1));
        z = (zero_fix < 0) ? 1'($urandom_range(0, 1)) : zero_fix[0];
        mem_ready = mr;
        zero = z;
        @(negedge clk);
        check_cycle(s, mr, z);
        adv = !s.wait_mem || mr;
        @(posedge clk);
        #1;
        cyc++;
      end while (!adv && cyc < 40);
      if (!adv) check("wait_bound", 32'(adv), 32'd1);
      if (s.wait_mem && !s.fetch_gate) wait_cycles = cyc;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1; op = 7'd0; funct3 = 3'd0; funct7b5 = 0; zero = 0; mem_ready = 1;
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(riscv_pkg::S_FETCH));
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("rel_pc_write", 32'(pc_write), 32'd1);
    check("rel_ir_write", 32'(ir_write), 32'd1);
    mem_ready = 0;
    @(posedge clk);
    #1;

    // lw with three wait cycles in MEMREAD
    run_instr(T_LOAD, 3'b010, 0, 3, -1);
    check("lw_memread_cycles", 32'(wait_cycles), 32'd4);
    run_instr(T_R, 3'b000, 1, -1, -1);     // sub
    run_instr(T_I, 3'b000, 1, -1, -1);     // addi with funct7b5 set
    run_instr(T_BR, 3'b001, 0, -1, 1);     // bne, zero=1: not taken
    run_instr(T_BR, 3'b111, 0, -1, 1);     // bgeu, zero=1: taken
    run_instr(T_BR, 3'b010, 0, -1, -1);    // illegal branch funct3
    run_instr(T_JALR, 3'b000, 0, -1, -1);
    run_instr(T_LUI, 3'b101, 1, -1, -1);
    run_instr(7'b1111111, 3'b000, 0, -1, -1);
    run_instr(T_STORE, 3'b010, 0, 2, -1);

    // Reset in the middle of a stalled store
    op = T_STORE; funct3 = 3'b010; funct7b5 = 0; mem_ready = 1;
    @(posedge clk);
    @(posedge clk);
    #1 mem_ready = 0;
    @(posedge clk);
    @(negedge clk);
    check("mw_state", 32'(state_dbg), 32'(riscv_pkg::S_MEMWRITE));
    check("mw_mem_write", 32'(mem_write), 32'd1);
    #2 reset = 1;
    #1;
    check("mwrst_mem_write", 32'(mem_write), 32'd0);
    check("mwrst_state", 32'(state_dbg), 32'(riscv_pkg::S_FETCH));
    mem_ready = 1;
    #1;
    check("mwrst_pc_write", 32'(pc_write), 32'd0);
    check("mwrst_ir_write", 32'(ir_write), 32'd0);
    @(posedge clk);
    #1;
    check("mwrst_hold_state", 32'(state_dbg), 32'(riscv_pkg::S_FETCH));
    @(negedge clk);
    reset = 0;
    #1;
    check("mwrel_state", 32'(state_dbg), 32'(riscv_pkg::S_FETCH));
    check("mwrel_pc_write", 32'(pc_write), 32'd1);
    mem_ready = 0;
    @(posedge clk);
    #1;

    // Random instruction stream
    for (int n = 0; n < 250; n++) begin
      logic [6:0] o;
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0: o = T_LOAD;   1: o = T_STORE; 2: o = T_R;   3: o = T_I;   4: o = T_LUI;
        5: o = T_AUIPC;  6: o = T_BR;    7: o = T_JAL; 8: o = T_JALR;
        default: o = 7'($urandom);
      endcase
      run_instr(o, 3'($urandom), 1'($urandom), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle RISC-V RV32I control unit and the producing end of the ALU interface.
- Decodes the latched instruction fields and sequences a Moore FSM.
- Drives the datapath muxes, write enables, `imm_src` and the 4-bit `alu_control`; consumes the ALU `zero` flag for branch resolution.
- One instruction completes every 3–5 cycles, plus memory wait cycles.

Parameters:
MEM_WAIT_EN  1  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready treated as constant 1
STATE_W  4  width of state encoding / state_dbg port

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag (alu_result==0)
mem_ready  input  1  memory access complete this cycle
pc_write  output  1  load PC from result bus
adr_src  output  1  0: memory address=PC, 1: address=ALUOut
mem_write  output  1  data memory write strobe
ir_write  output  1  latch instruction register and old_pc
reg_write  output  1  register file write
result_src  output  2  00 ALUOut reg, 01 read data reg, 10 alu_result direct
alu_src_a  output  2  00 PC, 01 old_pc, 10 rs1 data
alu_src_b  output  2  00 rs2 data, 01 immediate, 10 constant 4
imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
alu_control  output  4  ALU op code
illegal_instr  output  1  one-cycle pulse on unsupported op/funct3
state_dbg  output  STATE_W  current state

Behaviour:
- **ALU codes:** add 0000, sub 0001, or 0010, and 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001, lui 1111. Default is add.
- **Reset:** async set of state to FETCH.
  - While reset is high, pc_write, ir_write, reg_write, mem_write and illegal_instr are forced to 0.
  - After reset release, the first FETCH behaves normally.
- **Moore outputs:** all outputs are a function of state plus the gates listed below. Unlisted enables are 0, unlisted muxes are 00.
- **FETCH:** adr_src=0, src_a=00, src_b=10, add, result_src=10. pc_write=ir_write=mem_ready. Stay until mem_ready, then DECODE.
- **DECODE:** src_a=01, src_b=01, add (ALUOut = branch/jal target). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 or 0110111 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0010111 → AUIPC
  - else → ILLEGAL
- **MEMADR:** src_a=10, src_b=01, add. op[5]=0 → MEMREAD; op[5]=1 → MEMWRITE.
- **MEMREAD:** adr_src=1. Wait for mem_ready, then MEMWB.
- **MEMWB:** result_src=01, reg_write=1, then FETCH.
- **MEMWRITE:** adr_src=1, mem_write=1 held until mem_ready, then FETCH.
- **EXECUTER / EXECUTEI:** src_a=10; src_b=00 (R) or 01 (I). Then ALUWB.
  - alu_control decoded from funct3: 000 add (sub when R and funct7b5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra when funct7b5), 110 or, 111 and.
  - LUI uses EXECUTEI with alu_control=1111.
- **AUIPC:** src_a=01, src_b=01, add, then ALUWB.
- **ALUWB:** result_src=00, reg_write=1, then FETCH.
- **BRANCH:** src_a=10, src_b=00, result_src=00, pc_write=taken, then FETCH. Per funct3:
  - 000 sub, taken=zero
  - 001 sub, taken=!zero
  - 100 slt, taken=!zero
  - 101 slt, taken=zero
  - 110 sltu, taken=!zero
  - 111 sltu, taken=zero
  - 010/011 → ILLEGAL instead (no pc_write)
- **JAL:** src_a=01, src_b=10, add, result_src=00, pc_write=1, then ALUWB (rd = old_pc+4 written next cycle).
- **JALR:** src_a=10, src_b=01, add, result_src=10, pc_write=1, then JALR_LINK.
- **JALR_LINK:** src_a=01, src_b=10, add, result_src=10, reg_write=1, then FETCH. rs1 has already been consumed, so rd==rs1 is safe.
- **ILLEGAL:** illegal_instr=1 for exactly one cycle, no writes, then FETCH.
- **imm_src by op:** S for store, B for branch, J for jal, U for lui/auipc, else I.
- **Reset mid-instruction:** FSM returns to FETCH immediately; no partial write is committed after reset assertion.

Decomposition:
- Shared package `riscv_pkg`:
  - opcode constants
  - ALU code constants, matching the ALU encoding above
  - result_src, alu_src_a/b and imm_src encodings
  - state enum
- One sub-module: `alu_decoder` (combinational: funct3, funct7b5, op[5], state class → alu_control).
- `multicycle_control` keeps the FSM, next-state logic and output gating.

Test Plan:
- Reset asserted mid-MEMWRITE with mem_ready=0 → mem_write drops combinationally; state_dbg=FETCH after release.
- lw (op=0000011), mem_ready low 3 cycles in MEMREAD → FETCH, DECODE, MEMADR, MEMREAD×4, MEMWB. reg_write=1 with result_src=01 only in MEMWB.
- R-type sub (funct3=000, funct7b5=1) → alu_control=0001 in EXECUTER; ALUWB with reg_write=1. addi with funct7b5=1 → alu_control=0000.
- Branches:
  - bne with zero=1 → pc_write=0 in BRANCH.
  - bgeu (funct3=111) with zero=1 → alu_control=1001, pc_write=1.
  - funct3=010 → illegal_instr pulse, 1 cycle.
- jalr → JALR with pc_write=1 and result_src=10, then JALR_LINK with reg_write=1, src_a=01, src_b=10.
- lui → imm_src=100, alu_control=1111, src_b=01. Unknown op 1111111 → single illegal_instr pulse, then FETCH with no write strobes.
